data_io_tx: RTL and testbench

//  SPI master that emits the io-controller file-download protocol, so the core can push a

---
 rtl/data_io_tx.sv | 219 +++++++++++++++++++++
 tb/tb_data_io_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_io_tx.sv
// data_io_tx: SPI mode-0 master that sends the io-controller file-download
// sequence (begin frame, data frame read from a local RAM, end frame) to a
// data_io-style slave.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; ss high, sck low
// SETUP | ss low, first bit on sdo, CLK_DIV cycles before the first rise
// SHIFT | sck toggling every CLK_DIV cycles, bytes back to back
// HOLD  | sck low for CLK_DIV cycles after the last fall, then ss rises
// GAP   | ss high for SS_GAP cycles between frames
// DONE  | one-cycle done pulse, busy already low
module data_io_tx #(
   parameter int unsigned CLK_DIV    = 4,
   parameter logic [14:0] START_ADDR = 15'h0000,
   parameter int unsigned SS_GAP     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic [14:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_din,
   output logic        ss,
   output logic        sck,
   output logic        sdo
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LOAD = 8'(SS_GAP - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [1:0]  frame_q, frame_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  pref_q, pref_d;
   logic [14:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        rd_pend_q, rd_pend_d;
   logic        ss_q, ss_d;
   logic        sck_q, sck_d;
   logic        sdo_q, sdo_d;

   logic        enter;
   logic [1:0]  nf;
   logic [7:0]  hdr;
   logic [7:0]  next_byte;

   // Next-state logic: frame sequencing, sck generation, shifter and RAM prefetch.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      byte_cnt_d = byte_cnt_q;
      frame_d    = frame_q;
      shift_d    = shift_q;
      len_d      = len_q;
      pref_d     = pref_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      rd_pend_d  = mem_rd_q;
      ss_d       = ss_q;
      sck_d      = sck_q;
      sdo_d      = sdo_q;
      enter      = 1'b0;
      nf         = 2'd0;
      hdr        = 8'h53;
      next_byte  = 8'h00;

      if (mem_rd_q) mem_addr_d = mem_addr_q + 15'd1;
      if (rd_pend_q) pref_d = mem_din;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d      = len;
               mem_addr_d = START_ADDR;
               enter      = 1'b1;
               nf         = 2'd0;
            end
         end
         S_SETUP: begin
            if (div_q == 8'd0) begin
               sck_d   = 1'b1;
               div_d   = DIV_LOAD;
               state_d = S_SHIFT;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_SHIFT: begin
            if (div_q != 8'd0) begin
               div_d = div_q - 8'd1;
            end else begin
               div_d = DIV_LOAD;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (bit_q != 3'd0) begin
                     bit_d   = bit_q - 3'd1;
                     shift_d = {shift_q[6:0], 1'b0};
                     sdo_d   = shift_q[6];
                  end else if (byte_cnt_q != 16'd0) begin
                     case (frame_q)
                        2'd0:    next_byte = 8'hFF;
                        2'd1:    next_byte = pref_q;
                        default: next_byte = 8'h00;
                     endcase
                     shift_d    = next_byte;
                     sdo_d      = next_byte[7];
                     bit_d      = 3'd7;
                     byte_cnt_d = byte_cnt_q - 16'd1;
                     // Fetch the following data byte while this one shifts out.
                     mem_rd_d   = (frame_q == 2'd1) && (byte_cnt_d != 16'd0);
                  end else begin
                     state_d = S_HOLD;
                  end
               end
            end
         end
         S_HOLD: begin
            if (div_q == 8'd0) begin
               ss_d    = 1'b1;
               sdo_d   = 1'b0;
               div_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_GAP: begin
            if (div_q != 8'd0) begin
               div_d = div_q - 8'd1;
            end else if (frame_q == 2'd2) begin
               state_d = S_DONE;
            end else begin
               enter = 1'b1;
               // An empty download skips the data frame entirely.
               nf    = ((frame_q == 2'd0) && (len_q == 16'd0)) ? 2'd2 : frame_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (enter) begin
         hdr        = (nf == 2'd1) ? 8'h54 : 8'h53;
         state_d    = S_SETUP;
         frame_d    = nf;
         ss_d       = 1'b0;
         div_d      = DIV_LOAD;
         bit_d      = 3'd7;
         shift_d    = hdr;
         sdo_d      = hdr[7];
         byte_cnt_d = (nf == 2'd1) ? len_q : 16'd1;
         // Data byte 0 is fetched during SETUP of the data frame.
         mem_rd_d   = (nf == 2'd1);
      end
   end

   // State and datapath registers; reset returns the bus to idle immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         div_q      <= 8'd0;
         bit_q      <= 3'd0;
         byte_cnt_q <= 16'd0;
         frame_q    <= 2'd0;
         shift_q    <= 8'd0;
         len_q      <= 16'd0;
         pref_q     <= 8'd0;
         mem_addr_q <= START_ADDR;
         mem_rd_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         ss_q       <= 1'b1;
         sck_q      <= 1'b0;
         sdo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         byte_cnt_q <= byte_cnt_d;
         frame_q    <= frame_d;
         shift_q    <= shift_d;
         len_q      <= len_d;
         pref_q     <= pref_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         rd_pend_q  <= rd_pend_d;
         ss_q       <= ss_d;
         sck_q      <= sck_d;
         sdo_q      <= sdo_d;
      end
   end

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign ss       = ss_q;
   assign sck      = sck_q;
   assign sdo      = sdo_q;

endmodule

// File: tb/tb_data_io_tx.sv
// tb_data_io_tx: directed sequence of downloads with random RAM contents and
// lengths; an SPI slave monitor reassembles frames and timing, compared with
// the expected begin/data/end byte stream built from the RAM image.
module tb_data_io_tx;

   localparam int          CLK_DIV    = 4;
   localparam int          SS_GAP     = 8;
   localparam logic [14:0] START_ADDR = 15'h0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_din;
   logic        ss;
   logic        sck;
   logic        sdo;

   always #5 clk = ~clk;

   data_io_tx #(.CLK_DIV(CLK_DIV), .START_ADDR(START_ADDR), .SS_GAP(SS_GAP)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .len(len), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
      .ss(ss), .sck(sck), .sdo(sdo)
   );

   // RAM with one-cycle read latency
   logic [7:0] ram [0:32767];
   always @(posedge clk) if (mem_rd) mem_din <= ram[mem_addr];

   // Slave-side monitor
   int         cyc = 0;
   logic       prev_ss = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0, prev_rd = 1'b0;
   int         t_ssfall = 0, t_ssrise = -1, t_rise = -1000, t_sdo = -1000;
   int         nbits = 0, cur_bytes = 0;
   bit         first_rise = 1'b0;
   logic [7:0] sh = 8'h00;
   logic [7:0] rx_q[$];
   int         flen_q[$], part_q[$], gap_q[$], lead_q[$], rd_addr_q[$], done_gap_q[$];
   int         per_err = 0, stab_err = 0, idle_err = 0, rd_err = 0, done_cnt = 0;

   always @(negedge clk) begin
      cyc++;
      if (mem_rd) begin
         rd_addr_q.push_back(int'(mem_addr));
         if (prev_rd) rd_err++;
      end
      if (done) begin
         done_cnt++;
         done_gap_q.push_back(cyc - t_ssrise);
         if (!ss) idle_err++;
      end
      if (sdo !== prev_sdo && (!ss || !prev_ss)) begin
         if (cyc - t_rise < CLK_DIV) stab_err++;
         t_sdo = cyc;
      end
      if (prev_ss && !ss) begin
         gap_q.push_back(t_ssrise < 0 ? -1 : cyc - t_ssrise);
         t_ssfall = cyc; nbits = 0; cur_bytes = 0; first_rise = 1'b1;
      end
      if (!ss && sck && !prev_sck) begin
         if (first_rise) lead_q.push_back(cyc - t_ssfall);
         else if (cyc - t_rise != 2 * CLK_DIV) per_err++;
         if (cyc - t_sdo < CLK_DIV) stab_err++;
         first_rise = 1'b0;
         t_rise = cyc;
         sh = {sh[6:0], sdo};
         nbits++;
         if (nbits == 8) begin
            rx_q.push_back(sh);
            nbits = 0;
            cur_bytes++;
         end
      end
      if (!prev_ss && ss) begin
         flen_q.push_back(cur_bytes);
         part_q.push_back(nbits);
         t_ssrise = cyc;
      end
      if (ss && sck) idle_err++;
      prev_ss = ss; prev_sck = sck; prev_sdo = sdo; prev_rd = mem_rd;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_xfer(input int n, input bit spam);
      logic [7:0] exp_q[$];
      int expf[$];
      int rb, fb, gb, lb, ab, db, pe, se, ie, re, dc, limit;
      bit seen;
      exp_q = {8'h53, 8'hFF};
      expf.push_back(2);
      if (n > 0) begin
         exp_q.push_back(8'h54);
         for (int i = 0; i < n; i++) exp_q.push_back(ram[(int'(START_ADDR) + i) & 32'h7FFF]);
         expf.push_back(n + 1);
      end
      exp_q.push_back(8'h53);
      exp_q.push_back(8'h00);
      expf.push_back(2);

      rb = rx_q.size(); fb = flen_q.size(); gb = gap_q.size(); lb = lead_q.size();
      ab = rd_addr_q.size(); db = done_gap_q.size();
      pe = per_err; se = stab_err; ie = idle_err; re = rd_err; dc = done_cnt;
      limit = (n + 8) * 16 * CLK_DIV + 200;

      @(negedge clk); len = 16'(n); start = 1'b1;
      @(negedge clk); start = 1'b0; len = 16'($urandom);
      chk("busy_after_start", busy, 1);
      chk("ss_low_after_start", ss, 0);
      seen = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk("busy_at_done", busy, 0);
            chk("ss_at_done", ss, 1);
            if (spam) start = 1'b1;
         end else if (spam && busy) begin
            start = ($urandom_range(0, 15) == 0);
         end
      end
      chk("done_within_budget", seen, 1);
      @(negedge clk); start = 1'b0;
      repeat (4 * SS_GAP + 4 * CLK_DIV) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ss", ss, 1);
      chk("done_pulses", done_cnt - dc, 1);
      if (done_gap_q.size() > db) chk("done_after_ss_rise", done_gap_q[db], SS_GAP);

      chk("byte_count", rx_q.size() - rb, exp_q.size());
      for (int i = 0; i < exp_q.size() && rb + i < rx_q.size(); i++)
         chk($sformatf("byte%0d", i), rx_q[rb + i], exp_q[i]);
      chk("frame_count", flen_q.size() - fb, expf.size());
      for (int j = 0; j < expf.size() && fb + j < flen_q.size(); j++) begin
         chk($sformatf("frame%0d_len", j), flen_q[fb + j], expf[j]);
         chk($sformatf("frame%0d_partial", j), part_q[fb + j], 0);
      end
      for (int j = 1; j < expf.size() && gb + j < gap_q.size(); j++)
         chk($sformatf("gap%0d", j), gap_q[gb + j], SS_GAP);
      for (int j = 0; j < expf.size() && lb + j < lead_q.size(); j++)
         chk($sformatf("lead%0d", j), lead_q[lb + j], CLK_DIV);
      chk("rd_count", rd_addr_q.size() - ab, n);
      for (int i = 0; i < n && ab + i < rd_addr_q.size(); i++)
         chk($sformatf("rd_addr%0d", i), rd_addr_q[ab + i], (int'(START_ADDR) + i) & 32'h7FFF);
      chk("sck_period_err", per_err - pe, 0);
      chk("sdo_stability_err", stab_err - se, 0);
      chk("idle_sck_or_done_ss_err", idle_err - ie, 0);
      chk("rd_width_err", rd_err - re, 0);
   endtask

   initial begin
      int fb;
      bit hit;
      reset_n = 1'b0;
      start   = 1'b0;
      len     = 16'd0;
      for (int a = 0; a < 32768; a++) ram[a] = 8'($urandom);
      #12;
      chk("rst_ss", ss, 1);
      chk("rst_sck", sck, 0);
      chk("rst_sdo", sdo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, START_ADDR);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_xfer(0, 1'b0);
      ram[0] = 8'hA5; ram[1] = 8'h3C; ram[2] = 8'h81;
      run_xfer(3, 1'b0);
      for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
      run_xfer(5, 1'b0);
      run_xfer(int'($urandom_range(1, 12)), 1'b1);

      // asynchronous reset in the middle of data byte 2
      for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
      fb = flen_q.size();
      @(negedge clk); len = 16'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         hit = (flen_q.size() == fb + 1) && (cur_bytes == 3) && !ss;
      end
      chk("reach_f1_byte2", hit, 1);
      repeat (5) @(negedge clk);
      chk("pre_rst_ss_low", ss, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_ss", ss, 1);
      chk("midrst_sck", sck, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mem_addr", mem_addr, START_ADDR);
      @(negedge clk); reset_n = 1'b1;
      repeat (3) @(negedge clk);
      run_xfer(3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
